// File: rtl/spi_target_if.sv
// Signal bundle for spi_target: host SPI pins plus the CPU-side TX/RX byte handshake.
// The target uses the slave modport; whatever drives the pins and strobes uses master.
interface spi_target_if;
    logic       spi_cs_n;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_read;
    logic       rx_valid;
    logic       overrun;
    logic       overrun_clear;
    logic       busy;

    modport slave (
        input  spi_cs_n, spi_sck, spi_mosi, tx_data, tx_write, rx_read, overrun_clear,
        output spi_miso, spi_miso_oe, tx_full, rx_data, rx_valid, overrun, busy
    );

    modport master (
        output spi_cs_n, spi_sck, spi_mosi, tx_data, tx_write, rx_read, overrun_clear,
        input  spi_miso, spi_miso_oe, tx_full, rx_data, rx_valid, overrun, busy
    );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target, oversampled by clk: synchronises the host pins, shifts bytes in
// and out MSB first, and exposes a one-byte TX buffer and one-byte RX register.
module spi_target #(
    parameter logic [7:0] EMPTY_BYTE = 8'hFF
) (
    input  logic         clk,
    input  logic         rst,
    spi_target_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ABORT  = 2'd2
    } state_e;

    logic       cs_meta_q, cs_sync_q;
    logic       sck_meta_q, sck_sync_q, sck_prev_q;
    logic       mosi_meta_q, mosi_sync_q;
    logic [1:0] settle_q;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic       tx_full_q, tx_full_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic       miso_q, miso_d;
    logic       miso_oe_q, miso_oe_d;
    logic       busy_q, busy_d;

    logic       sck_rise_s, sck_fall_s;
    logic       load_s, rx_done_s;

    // Two-flop synchronisers plus the sck history flop; settle_q counts the refill after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            settle_q    <= 2'd0;
        end else begin
            cs_meta_q   <= bus.spi_cs_n;
            cs_sync_q   <= cs_meta_q;
            sck_meta_q  <= bus.spi_sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            mosi_meta_q <= bus.spi_mosi;
            mosi_sync_q <= mosi_meta_q;
            settle_q    <= (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        end
    end

    assign sck_rise_s = sck_sync_q & ~sck_prev_q;
    assign sck_fall_s = ~sck_sync_q & sck_prev_q;

    // Next-state: FSM, shifters, TX buffer, RX register and registered pin/status outputs
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        load_s     = 1'b0;
        rx_done_s  = 1'b0;

        case (state_q)
            // The reset values of cs_sync_q read as "deselected", so ABORT must
            // wait for real pin samples before it may release to IDLE.
            ST_ABORT: begin
                if ((settle_q == 2'd2) && cs_sync_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ABORT;
                end
            end
            ST_IDLE: begin
                if (!cs_sync_q) begin
                    state_d   = ST_ACTIVE;
                    load_s    = 1'b1;
                    bit_cnt_d = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_sync_q) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                end else if (sck_rise_s) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi_sync_q};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    rx_done_s  = (bit_cnt_q == 3'd7);
                end else if (sck_fall_s) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b1};
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_ABORT;
            end
        endcase

        // The load sees the buffer as it was before any write in the same cycle
        if (load_s) begin
            tx_shift_d = tx_full_q ? tx_buf_q : EMPTY_BYTE;
            tx_full_d  = 1'b0;
        end else begin
            tx_shift_d = tx_shift_d;
        end
        if (bus.tx_write) begin
            tx_buf_d  = bus.tx_data;
            tx_full_d = 1'b1;
        end else begin
            tx_buf_d = tx_buf_q;
        end

        if (rx_done_s) begin
            rx_data_d  = {rx_shift_q, mosi_sync_q};
            rx_valid_d = 1'b1;
        end else if (bus.rx_read) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        if (rx_done_s && rx_valid_q && !bus.rx_read) begin
            overrun_d = 1'b1;
        end else if (bus.overrun_clear) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        busy_d    = (state_d == ST_ACTIVE);
        miso_oe_d = (state_d == ST_ACTIVE);
        miso_d    = (state_d == ST_ACTIVE) ? tx_shift_d[7] : 1'b1;
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ABORT;
            bit_cnt_q  <= 3'd0;
            tx_shift_q <= EMPTY_BYTE;
            tx_buf_q   <= 8'h00;
            tx_full_q  <= 1'b0;
            rx_shift_q <= 7'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            miso_q     <= 1'b1;
            miso_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = miso_oe_q;
    assign bus.tx_full     = tx_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.overrun     = overrun_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a host model bit-bangs SCK at clk/8 and every
// expectation is a hand-computed constant checked with an immediate assertion.
module tb_spi_target;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [7:0] r;

    spi_target_if bus ();

    spi_target #(.EMPTY_BYTE(8'hFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_write = 1'b1;
        hold(1);
        bus.tx_write = 1'b0;
    endtask

    task automatic rd();
        bus.rx_read = 1'b1;
        hold(1);
        bus.rx_read = 1'b0;
        hold(1);
    endtask

    task automatic cs_low();
        bus.spi_cs_n = 1'b0;
        hold(8);
    endtask

    task automatic cs_high();
        hold(4);
        bus.spi_cs_n = 1'b1;
        hold(8);
    endtask

    // Host clocks nbits MSB first; optional rx_read in the completion cycle or latency probe
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit read_last,
                            input bit chk_lat, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = tx[7-i];
            hold(4);
            rx = {rx[6:0], bus.spi_miso};
            bus.spi_sck = 1'b1;
            if (i == 7 && (read_last || chk_lat)) begin
                hold(2);
                if (chk_lat) chk("lat_before", {7'd0, bus.rx_valid}, 8'd0);
                if (read_last) bus.rx_read = 1'b1;
                hold(1);
                bus.rx_read = 1'b0;
                if (chk_lat) chk("lat_after", {7'd0, bus.rx_valid}, 8'd1);
                hold(1);
            end else begin
                hold(4);
            end
            bus.spi_sck = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.spi_cs_n = 1'b1;
        bus.spi_sck = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_write = 1'b0;
        bus.rx_read = 1'b0;
        bus.overrun_clear = 1'b0;
        hold(3);
        chk("rst_miso", {7'd0, bus.spi_miso}, 8'd1);
        chk("rst_oe", {7'd0, bus.spi_miso_oe}, 8'd0);
        chk("rst_busy", {7'd0, bus.busy}, 8'd0);
        chk("rst_rxd", bus.rx_data, 8'h00);
        chk("rst_rxv", {7'd0, bus.rx_valid}, 8'd0);
        chk("rst_ovr", {7'd0, bus.overrun}, 8'd0);
        chk("rst_txf", {7'd0, bus.tx_full}, 8'd0);
        rst = 1'b0;
        hold(6);

        // Basic exchange: A5 out, 3C in
        wr(8'hA5);
        chk("t1_txf_set", {7'd0, bus.tx_full}, 8'd1);
        cs_low();
        chk("t1_busy", {7'd0, bus.busy}, 8'd1);
        chk("t1_oe", {7'd0, bus.spi_miso_oe}, 8'd1);
        spi_bits(8'h3C, 8, 1'b0, 1'b1, r);
        chk("t1_miso_byte", r, 8'hA5);
        chk("t1_rxd", bus.rx_data, 8'h3C);
        chk("t1_rxv", {7'd0, bus.rx_valid}, 8'd1);
        chk("t1_txf_clr", {7'd0, bus.tx_full}, 8'd0);
        cs_high();
        chk("t1_idle_oe", {7'd0, bus.spi_miso_oe}, 8'd0);
        chk("t1_idle_busy", {7'd0, bus.busy}, 8'd0);
        chk("t1_idle_miso", {7'd0, bus.spi_miso}, 8'd1);
        rd();
        chk("t1_read_rxv", {7'd0, bus.rx_valid}, 8'd0);
        chk("t1_read_hold", bus.rx_data, 8'h3C);

        // Nothing queued: empty byte returned
        cs_low();
        spi_bits(8'h00, 8, 1'b0, 1'b0, r);
        chk("t2_empty", r, 8'hFF);
        chk("t2_rxd", bus.rx_data, 8'h00);
        cs_high();
        rd();

        // Overwrite before frame, mid-frame refill, two bytes without read -> overrun
        wr(8'h12);
        wr(8'h34);
        chk("t3_txf", {7'd0, bus.tx_full}, 8'd1);
        cs_low();
        chk("t3_txf_load", {7'd0, bus.tx_full}, 8'd0);
        wr(8'hC3);
        spi_bits(8'h11, 8, 1'b0, 1'b0, r);
        chk("t3_tx_ovw", r, 8'h34);
        chk("t3_ovr_none", {7'd0, bus.overrun}, 8'd0);
        spi_bits(8'h22, 8, 1'b0, 1'b0, r);
        chk("t3_b2b", r, 8'hC3);
        chk("t3_rxd", bus.rx_data, 8'h22);
        chk("t3_ovr", {7'd0, bus.overrun}, 8'd1);
        chk("t3_rxv", {7'd0, bus.rx_valid}, 8'd1);
        bus.overrun_clear = 1'b1;
        hold(1);
        bus.overrun_clear = 1'b0;
        chk("t3_ovr_clr", {7'd0, bus.overrun}, 8'd0);
        cs_high();
        rd();

        // rx_read coincident with completion: no overrun
        cs_low();
        spi_bits(8'h11, 8, 1'b0, 1'b0, r);
        spi_bits(8'h22, 8, 1'b1, 1'b0, r);
        chk("t4_rxv", {7'd0, bus.rx_valid}, 8'd1);
        chk("t4_rxd", bus.rx_data, 8'h22);
        chk("t4_ovr", {7'd0, bus.overrun}, 8'd0);
        cs_high();
        rd();

        // Abort after 5 bits, then an aligned full frame
        cs_low();
        spi_bits(8'hF0, 5, 1'b0, 1'b0, r);
        cs_high();
        chk("t5_partial_rxv", {7'd0, bus.rx_valid}, 8'd0);
        cs_low();
        spi_bits(8'h7E, 8, 1'b0, 1'b0, r);
        chk("t5_rxd", bus.rx_data, 8'h7E);
        chk("t5_rxv", {7'd0, bus.rx_valid}, 8'd1);
        cs_high();
        rd();

        // Reset mid-byte with CS held low: stay out until CS rises
        wr(8'h5C);
        cs_low();
        spi_bits(8'hAA, 3, 1'b0, 1'b0, r);
        rst = 1'b1;
        hold(2);
        rst = 1'b0;
        hold(6);
        chk("t6_busy", {7'd0, bus.busy}, 8'd0);
        chk("t6_miso", {7'd0, bus.spi_miso}, 8'd1);
        chk("t6_oe", {7'd0, bus.spi_miso_oe}, 8'd0);
        spi_bits(8'h81, 8, 1'b0, 1'b0, r);
        chk("t6_ign_miso", r, 8'hFF);
        chk("t6_ign_rxv", {7'd0, bus.rx_valid}, 8'd0);
        chk("t6_ign_busy", {7'd0, bus.busy}, 8'd0);
        cs_high();
        wr(8'hA0);
        cs_low();
        chk("t6_rejoin", {7'd0, bus.busy}, 8'd1);
        spi_bits(8'h96, 8, 1'b0, 1'b0, r);
        chk("t6_tx", r, 8'hA0);
        chk("t6_rxd", bus.rx_data, 8'h96);
        cs_high();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
